instr_fetch_unit: RTL and testbench

- Instruction-side front end of the multi-cycle TSC CPU: owns the PC, requests instruction words from memory over the readM / input_ready handshake, and presents each fetched 16-bit word to the control unit and decoder.
- Handshake to execute: instr_valid / instr_ack.
- Next PC comes from the datapath's redirect request (branch/jump target) or PC+1.

---
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: groups the memory read handshake and the execute-side
// instruction handshake of the fetch unit.
//   master : fetch unit side (drives readM, i_address, instr, instr_valid, pc)
//   slave  : memory / execute side (drives i_data, input_ready, instr_ack,
//            pc_load, pc_target, halt)
interface instr_fetch_unit_if #(
  parameter int unsigned WORD_SIZE = 16
);
  // Memory side
  logic                 readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 input_ready;
  // Execute side
  logic [WORD_SIZE-1:0] instr;
  logic                 instr_valid;
  logic                 instr_ack;
  logic                 pc_load;
  logic [WORD_SIZE-1:0] pc_target;
  logic                 halt;
  logic [WORD_SIZE-1:0] pc;

  modport master (
    output readM, i_address, instr, instr_valid, pc,
    input  i_data, input_ready, instr_ack, pc_load, pc_target, halt
  );

  modport slave (
    input  readM, i_address, instr, instr_valid, pc,
    output i_data, input_ready, instr_ack, pc_load, pc_target, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction word at a time
// over the readM / input_ready handshake and presents it to execute through
// instr_valid / instr_ack. Next PC is pc_target on a redirect, else pc+1.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_fetch_unit_if.master (memory + execute handshakes)
//   num_inst : accepted-instruction counter (only with INST_COUNT_EN)
// Optional feature macro: INST_COUNT_EN.
module instr_fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_fetch_unit_if.master    bus
`ifdef INST_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0]  num_inst
`endif
);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StHalted
  } state_e;

  state_e               state_q, state_d;
  logic                 readm_q, readm_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      readm_q <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      readm_q <= readm_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    readm_d = readm_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    unique case (state_q)
      StFetch: begin
        readm_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // input_ready is only meaningful here; strobes in other states are dropped
        if (bus.input_ready) begin
          instr_d = bus.i_data;
          valid_d = 1'b1;
          readm_d = 1'b0;
          state_d = StHold;
        end
      end
      StHold: begin
        // instr_valid is always set in this state, so instr_ack alone means accepted
        if (bus.instr_ack) begin
          valid_d = 1'b0;
          if (bus.halt) begin
            state_d = StHalted;
          end else if (bus.pc_load) begin
            pc_d    = bus.pc_target;
            state_d = StFetch;
          end else begin
            pc_d    = pc_q + WORD_SIZE'(1);
            state_d = StFetch;
          end
        end
      end
      StHalted: begin
        readm_d = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = StFetch;
    endcase
  end

  assign bus.readM       = readm_q;
  assign bus.i_address   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;

`ifdef INST_COUNT_EN
  logic [WORD_SIZE-1:0] num_inst_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst_q <= '0;
    end else if (valid_q && bus.instr_ack) begin
      num_inst_q <= num_inst_q + WORD_SIZE'(1);
    end
  end

  assign num_inst = num_inst_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_instr_fetch_unit;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  instr_fetch_unit_if #(.WORD_SIZE(16)) bus ();

`ifdef INST_COUNT_EN
  logic [15:0] num_inst;
`endif

  instr_fetch_unit #(
    .WORD_SIZE(16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
`ifdef INST_COUNT_EN
    ,
    .num_inst(num_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for readM, then answer it after lat cycles with data.
  task automatic serve_fetch(input logic [15:0] data, input int lat, input logic [15:0] addr);
    int n;
    n = 0;
    while (bus.readM !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.readM !== 1'b1) begin
      bad++;
      $display("FAIL fetch_req readM=%b required 1", bus.readM);
    end
    for (int i = 0; i < lat - 1; i++) begin
      total++;
      if (bus.i_address !== addr) begin
        bad++;
        $display("FAIL fetch_addr i_address=%h required %h", bus.i_address, addr);
      end
      @(negedge clk);
    end
    total++;
    if (bus.i_address !== addr) begin
      bad++;
      $display("FAIL fetch_addr i_address=%h required %h", bus.i_address, addr);
    end
    bus.i_data      = data;
    bus.input_ready = 1'b1;
    @(negedge clk);
    bus.input_ready = 1'b0;
    bus.i_data      = 16'hxxxx;
    total++;
    if (bus.instr !== data || bus.instr_valid !== 1'b1 || bus.readM !== 1'b0) begin
      bad++;
      $display("FAIL fetch_done instr=%h valid=%b readM=%b required %h 1 0",
               bus.instr, bus.instr_valid, bus.readM, data);
    end
  endtask

  task automatic do_ack(input logic h, input logic ld, input logic [15:0] tgt);
    bus.instr_ack = 1'b1;
    bus.halt      = h;
    bus.pc_load   = ld;
    bus.pc_target = tgt;
    @(negedge clk);
    bus.instr_ack = 1'b0;
    bus.halt      = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_target = ~tgt; // later target changes must not matter
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if (bus.pc !== 16'h0000 || bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0 ||
        bus.readM !== 1'b0) begin
      bad++;
      $display("FAIL reset_state pc=%h instr=%h valid=%b readM=%b required 0000 0000 0 0",
               bus.pc, bus.instr, bus.instr_valid, bus.readM);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    total++;
    if (bus.readM !== 1'b0) begin
      bad++;
      $display("FAIL reset_release readM=%b required 0", bus.readM);
    end
    @(negedge clk);
    total++;
    if (bus.readM !== 1'b1 || bus.i_address !== 16'h0000) begin
      bad++;
      $display("FAIL first_req readM=%b i_address=%h required 1 0000", bus.readM, bus.i_address);
    end
    serve_fetch(16'h6A05, 3, 16'h0000);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      bus.input_ready = i[0];
      bus.i_data      = 16'hBEEF;
      @(negedge clk);
      total++;
      if (bus.instr !== 16'h6A05 || bus.pc !== 16'h0000 || bus.instr_valid !== 1'b1 ||
          bus.readM !== 1'b0) begin
        bad++;
        $display("FAIL hold instr=%h pc=%h valid=%b readM=%b required 6a05 0000 1 0",
                 bus.instr, bus.pc, bus.instr_valid, bus.readM);
      end
    end
    bus.input_ready = 1'b0;
  endtask

  task automatic test_sequential_redirect();
    do_ack(1'b0, 1'b1, 16'h0004);
    total++;
    if (bus.instr_valid !== 1'b0 || bus.readM !== 1'b0) begin
      bad++;
      $display("FAIL ack_clear valid=%b readM=%b required 0 0", bus.instr_valid, bus.readM);
    end
    @(negedge clk);
    total++;
    if (bus.readM !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back readM=%b required 1", bus.readM);
    end
    serve_fetch(16'h1111, 1, 16'h0004);
    do_ack(1'b0, 1'b0, 16'h0099);
    serve_fetch(16'h2222, 2, 16'h0005);
    do_ack(1'b0, 1'b1, 16'h0020);
    serve_fetch(16'h3333, 1, 16'h0020);
    total++;
    if (bus.pc !== 16'h0020) begin
      bad++;
      $display("FAIL target_sample pc=%h required 0020", bus.pc);
    end
  endtask

  task automatic test_wrap_priority();
    do_ack(1'b0, 1'b1, 16'hFFFF);
    serve_fetch(16'h4444, 1, 16'hFFFF);
    do_ack(1'b0, 1'b0, 16'h0000);
    // ack while instr_valid=0 must be ignored
    bus.instr_ack = 1'b1;
    bus.pc_load   = 1'b1;
    bus.pc_target = 16'h0055;
    @(negedge clk);
    @(negedge clk);
    bus.instr_ack = 1'b0;
    bus.pc_load   = 1'b0;
    serve_fetch(16'h5555, 1, 16'h0000);
    do_ack(1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      bus.input_ready = i[0];
      bus.i_data      = 16'hCAFE;
      @(negedge clk);
      total++;
      if (bus.readM !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 16'h0000) begin
        bad++;
        $display("FAIL halted readM=%b valid=%b pc=%h required 0 0 0000",
                 bus.readM, bus.instr_valid, bus.pc);
      end
    end
    bus.input_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    serve_fetch(16'h7777, 1, 16'h0000);
    do_ack(1'b0, 1'b1, 16'h0007);
    @(negedge clk);
    total++;
    if (bus.readM !== 1'b1 || bus.pc !== 16'h0007) begin
      bad++;
      $display("FAIL wait_state readM=%b pc=%h required 1 0007", bus.readM, bus.pc);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.readM !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 16'h0000 ||
        bus.i_address !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset readM=%b valid=%b pc=%h i_address=%h required 0 0 0000 0000",
               bus.readM, bus.instr_valid, bus.pc, bus.i_address);
    end
    @(negedge clk);
    reset_n         = 1'b1;
    bus.input_ready = 1'b1; // stale completion of the abandoned request
    bus.i_data      = 16'hDEAD;
    @(negedge clk);
    bus.input_ready = 1'b0;
    total++;
    if (bus.readM !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000) begin
      bad++;
      $display("FAIL stale_ready readM=%b valid=%b instr=%h required 1 0 0000",
               bus.readM, bus.instr_valid, bus.instr);
    end
    serve_fetch(16'h8888, 2, 16'h0000);
  endtask

`ifdef INST_COUNT_EN
  task automatic test_inst_count();
    reset_n = 1'b0;
    #1;
    total++;
    if (num_inst !== 16'd0) begin
      bad++;
      $display("FAIL count_reset num_inst=%0d required 0", num_inst);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        bus.instr_ack = 1'b1; // not accepted: instr_valid=0
        @(negedge clk);
        bus.instr_ack = 1'b0;
      end
      serve_fetch(16'(i + 16'h0100), 1, 16'(i));
      do_ack(1'b0, 1'b0, 16'h0000);
    end
    total++;
    if (num_inst !== 16'd9) begin
      bad++;
      $display("FAIL inst_count num_inst=%0d required 9", num_inst);
    end
  endtask
`endif

  initial begin
    total           = 0;
    bad             = 0;
    reset_n         = 1'b0;
    bus.i_data      = 16'h0000;
    bus.input_ready = 1'b0;
    bus.instr_ack   = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_target   = 16'h0000;
    bus.halt        = 1'b0;
    test_reset();
    test_hold();
    test_sequential_redirect();
    test_wrap_priority();
    test_async_reset();
`ifdef INST_COUNT_EN
    test_inst_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
